// File: rtl/writing_index_score_if.sv
// writing_index_score_if: bundles the write-generator's control inputs and its RAM write port.
interface writing_index_score_if #(
  parameter int N = 5,
  parameter int BitAddr = $clog2(N),
  parameter int addr_lenght = (N+1)*(N+1)-1
);
  logic               en_ins;
  logic               en_init;
  logic               hit;
  logic [BitAddr:0]   i;
  logic [BitAddr:0]   j;
  logic [BitAddr:0]   addr_init;
  logic [8:0]         max;
  logic [8:0]         data_init;
  logic [addr_lenght:0] addr_out;
  logic [8:0]         data_out;
  modport master (
    output en_ins, en_init, hit, i, j, addr_init, max, data_init,
    input  addr_out, data_out
  );
  modport slave (
    input  en_ins, en_init, hit, i, j, addr_init, max, data_init,
    output addr_out, data_out
  );
endinterface

// File: rtl/writing_index_score.sv
// writing_index_score: registered address/data generator for the Needleman-Wunsch score RAM.
// Optional range checking of init/insert indices is enabled by defining BOUNDS_CHECK_EN.
module writing_index_score #(
  parameter int N = 5,
  parameter int BitAddr = $clog2(N),
  parameter int addr_lenght = (N+1)*(N+1)-1
) (
  input logic clk,
  input logic rst,
  writing_index_score_if.slave bus
);
  localparam int AW = addr_lenght + 1;
  localparam logic [AW-1:0] NP1 = AW'(N+1);
  localparam logic [AW-1:0] ONE = AW'(1);
  logic [AW-1:0] r_addr;
  logic [8:0]    r_data;
  logic [AW-1:0] w_row_addr;
  logic [AW-1:0] w_col_addr;
  logic [AW-1:0] w_ins_addr;
  logic          w_init_ok;
  logic          w_ins_ok;
  logic          w_do_init;
  logic          w_do_ins;
  assign w_row_addr = AW'(bus.addr_init);
  assign w_col_addr = AW'(bus.addr_init) * NP1;
  assign w_ins_addr = (AW'(bus.i) + ONE) * NP1 + AW'(bus.j) + ONE;
`ifdef BOUNDS_CHECK_EN
  localparam logic [BitAddr:0] NI = (BitAddr+1)'(N);
  assign w_init_ok = bus.addr_init <= NI;
  assign w_ins_ok  = (bus.i < NI) && (bus.j < NI);
`else
  assign w_init_ok = 1'b1;
  assign w_ins_ok  = 1'b1;
`endif
  // init has priority: an asserted en_init blocks insertion even when its own index is rejected
  assign w_do_init = bus.en_init & w_init_ok;
  assign w_do_ins  = bus.en_ins & ~bus.en_init & w_ins_ok;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr <= '0;
      r_data <= '0;
    end else if (w_do_init) begin
      r_addr <= bus.hit ? w_col_addr : w_row_addr;
      r_data <= bus.data_init;
    end else if (w_do_ins) begin
      r_addr <= w_ins_addr;
      r_data <= bus.max;
    end
  end
  assign bus.addr_out = r_addr;
  assign bus.data_out = r_data;
endmodule

// File: tb/tb_writing_index_score.sv
// tb_writing_index_score: directed self-checking bench for writing_index_score with N=5.
module tb_writing_index_score;
  localparam int N  = 5;
  localparam int BA = $clog2(N);
  localparam int AW = (N+1)*(N+1);
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vecs = 0;
  int errs = 0;
  always #5 clk = ~clk;
  writing_index_score_if #(.N(N)) bus ();
  writing_index_score #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic drive(input logic ei, input logic ins, input logic h,
                       input int ii, input int jj, input int ai, input int mx, input int di);
    bus.en_init   = ei;
    bus.en_ins    = ins;
    bus.hit       = h;
    bus.i         = (BA+1)'(ii);
    bus.j         = (BA+1)'(jj);
    bus.addr_init = (BA+1)'(ai);
    bus.max       = 9'(mx);
    bus.data_init = 9'(di);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    drive($urandom_range(1), $urandom_range(1), $urandom_range(1), $urandom_range(15),
          $urandom_range(15), $urandom_range(15), $urandom_range(511), $urandom_range(511));
    #2 rst = 1'b0;
    #1;
    vecs++; if (bus.addr_out !== AW'(0)) begin errs++; $display("FAIL reset_async addr got %0d want 0", bus.addr_out); end
    vecs++; if (bus.data_out !== 9'd0) begin errs++; $display("FAIL reset_async data got %0d want 0", bus.data_out); end
    @(negedge clk);
    drive(0, 0, 0, 3, 3, 3, 99, 99);
    rst = 1'b1;
    tick();
    vecs++; if (bus.addr_out !== AW'(0)) begin errs++; $display("FAIL reset_idle addr got %0d want 0", bus.addr_out); end
    vecs++; if (bus.data_out !== 9'd0) begin errs++; $display("FAIL reset_idle data got %0d want 0", bus.data_out); end
  endtask

  task automatic test_init;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    vecs++; if (bus.addr_out !== AW'(0) || bus.data_out !== 9'd0) begin errs++; $display("FAIL init_row0_k0 got %0d/%0d want 0/0", bus.addr_out, bus.data_out); end
    drive(1, 0, 1, 0, 0, 0, 0, 0);
    tick();
    vecs++; if (bus.addr_out !== AW'(0) || bus.data_out !== 9'd0) begin errs++; $display("FAIL init_col0_k0 got %0d/%0d want 0/0", bus.addr_out, bus.data_out); end
    drive(1, 0, 0, 0, 0, 1, 0, 1);
    tick();
    vecs++; if (bus.addr_out !== AW'(1) || bus.data_out !== 9'd1) begin errs++; $display("FAIL init_row0_k1 got %0d/%0d want 1/1", bus.addr_out, bus.data_out); end
    drive(1, 0, 1, 0, 0, 1, 0, 1);
    tick();
    vecs++; if (bus.addr_out !== AW'(6) || bus.data_out !== 9'd1) begin errs++; $display("FAIL init_col0_k1 got %0d/%0d want 6/1", bus.addr_out, bus.data_out); end
  endtask

  task automatic test_insert;
    drive(0, 1, 0, 0, 0, 0, 3, 0);
    tick();
    vecs++; if (bus.addr_out !== AW'(7) || bus.data_out !== 9'd3) begin errs++; $display("FAIL ins_0_0 got %0d/%0d want 7/3", bus.addr_out, bus.data_out); end
    drive(0, 1, 0, 1, 0, 0, 6, 0);
    tick();
    vecs++; if (bus.addr_out !== AW'(13) || bus.data_out !== 9'd6) begin errs++; $display("FAIL ins_1_0 got %0d/%0d want 13/6", bus.addr_out, bus.data_out); end
    drive(0, 1, 0, 4, 4, 0, 511, 0);
    tick();
    vecs++; if (bus.addr_out !== AW'(35) || bus.data_out !== 9'd511) begin errs++; $display("FAIL ins_4_4 got %0d/%0d want 35/511", bus.addr_out, bus.data_out); end
    drive(0, 1, 0, 2, 3, 0, 256, 0);
    tick();
    vecs++; if (bus.addr_out !== AW'(22) || bus.data_out !== 9'd256) begin errs++; $display("FAIL ins_2_3 got %0d/%0d want 22/256", bus.addr_out, bus.data_out); end
  endtask

  task automatic test_priority_hold;
    drive(1, 1, 1, 0, 0, 5, 77, 100);
    tick();
    vecs++; if (bus.addr_out !== AW'(30) || bus.data_out !== 9'd100) begin errs++; $display("FAIL prio_init got %0d/%0d want 30/100", bus.addr_out, bus.data_out); end
    drive(0, 0, 1, 2, 2, 3, 5, 9);
    tick();
    vecs++; if (bus.addr_out !== AW'(30) || bus.data_out !== 9'd100) begin errs++; $display("FAIL idle_hold1 got %0d/%0d want 30/100", bus.addr_out, bus.data_out); end
    tick();
    vecs++; if (bus.addr_out !== AW'(30) || bus.data_out !== 9'd100) begin errs++; $display("FAIL idle_hold2 got %0d/%0d want 30/100", bus.addr_out, bus.data_out); end
  endtask

  task automatic test_bounds;
    drive(0, 1, 0, 5, 0, 0, 44, 0);
    tick();
`ifdef BOUNDS_CHECK_EN
    vecs++; if (bus.addr_out !== AW'(30) || bus.data_out !== 9'd100) begin errs++; $display("FAIL bounds_ins_i5 got %0d/%0d want 30/100", bus.addr_out, bus.data_out); end
    drive(1, 0, 0, 0, 0, 6, 0, 12);
    tick();
    vecs++; if (bus.addr_out !== AW'(30) || bus.data_out !== 9'd100) begin errs++; $display("FAIL bounds_init_k6 got %0d/%0d want 30/100", bus.addr_out, bus.data_out); end
`else
    vecs++; if (bus.addr_out !== AW'(37) || bus.data_out !== 9'd44) begin errs++; $display("FAIL nobounds_ins_i5 got %0d/%0d want 37/44", bus.addr_out, bus.data_out); end
`endif
  endtask

  task automatic test_mid_reset;
    drive(0, 1, 0, 1, 0, 0, 6, 0);
    tick();
    vecs++; if (bus.addr_out !== AW'(13) || bus.data_out !== 9'd6) begin errs++; $display("FAIL midrst_pre got %0d/%0d want 13/6", bus.addr_out, bus.data_out); end
    #2 rst = 1'b0;
    #1;
    vecs++; if (bus.addr_out !== AW'(0) || bus.data_out !== 9'd0) begin errs++; $display("FAIL midrst_async got %0d/%0d want 0/0", bus.addr_out, bus.data_out); end
    tick();
    vecs++; if (bus.addr_out !== AW'(0) || bus.data_out !== 9'd0) begin errs++; $display("FAIL midrst_held got %0d/%0d want 0/0", bus.addr_out, bus.data_out); end
    rst = 1'b1;
    tick();
    vecs++; if (bus.addr_out !== AW'(13) || bus.data_out !== 9'd6) begin errs++; $display("FAIL midrst_resume got %0d/%0d want 13/6", bus.addr_out, bus.data_out); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_insert();
    test_priority_hold();
    test_bounds();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
